// File: rtl/fixed_to_float_seq_pkg.sv
// Shared single-precision float definitions.
// Field widths, exponent bias and slice/pack helpers for the IEEE-754 single
// format. The same package is meant to be imported by every float-domain block
// (fixed<->float converters, multiplier, adder/subtractor), so they all agree
// on field layout.
package fixed_to_float_seq_pkg;

  localparam int FP_W      = 32;
  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  function automatic logic fp_sign(input logic [FP_W-1:0] f);
    return f[FP_W-1];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] f);
    return f[FP_W-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [FP_W-1:0] f);
    return f[FP_MANT_W-1:0];
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input logic                 s,
                                               input logic [FP_EXP_W-1:0]  e,
                                               input logic [FP_MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fixed_to_float_seq_abs.sv
// Sign/magnitude split of a two's-complement word.
// Ports:
//   data  in  WIDTH  signed operand
//   sign  out 1      data[WIDTH-1]
//   mag   out WIDTH  |data| as an unsigned WIDTH-bit value
// The magnitude keeps the full WIDTH bits, so the most negative input
// (-2^(WIDTH-1)) maps to 2^(WIDTH-1) without overflow.
module fixed_abs #(
  parameter int WIDTH = 22
) (
  input  logic [WIDTH-1:0] data,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  always_comb begin
    sign = data[WIDTH-1];
    mag  = sign ? (~data + WIDTH'(1)) : data;
  end

endmodule

// File: rtl/fixed_to_float_seq.sv
// Sequential signed fixed-point to IEEE-754 single converter.
// The magnitude is normalised one bit per clock, so latency depends on the
// number of leading zeros (at most WIDTH edges after the accepting edge; a
// zero operand takes one edge).
// Ports:
//   clk     in  1      rising-edge clock
//   reset   in  1      asynchronous, active-high
//   enable  in  1      request level, held until done has been consumed
//   data    in  WIDTH  signed fixed-point operand, value = data / 2^FRAC_BITS
//   result  out 32     IEEE-754 single, valid while done=1
//   done    out 1      high from completion until enable falls
// Handshake: a request is accepted on an edge where the converter is idle and
// enable=1. done rises together with result and stays up while enable stays
// high. The converter returns to idle on the first edge with enable=0; a new
// request needs enable low for at least one edge. Dropping enable before done
// aborts the conversion with result untouched.
module fixed_to_float_seq
  import fixed_to_float_seq_pkg::*;
#(
  parameter int WIDTH     = 22,
  parameter int FRAC_BITS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [31:0]      result,
  output logic             done
);

  // Shift count never exceeds WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  // Exponent of a value whose leading one sits at bit WIDTH-1 of mag.
  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + WIDTH - 1 - FRAC_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;

  logic               in_sign;
  logic [WIDTH-1:0]   in_mag;
  logic [FP_EXP_W-1:0]  exp_field;
  logic [FP_MANT_W-1:0] mant_field;
  logic [31:0]        packed_word;

  fixed_abs #(.WIDTH(WIDTH)) u_abs (
    .data (data),
    .sign (in_sign),
    .mag  (in_mag)
  );

  // Pack: once mag[WIDTH-1] is set it is the hidden bit. Left-aligning mag
  // into 25 bits puts the hidden bit at bit 24, so bits 23:1 are the
  // mantissa for any WIDTH in 2..25 (bit 0 is only non-zero when WIDTH=25
  // and mag=2^24, where it is zero anyway).
  always_comb begin
    exp_field   = EXP_TOP - FP_EXP_W'(cnt_q);
    mant_field  = FP_MANT_W'((25'(mag_q) << (25 - WIDTH)) >> 1);
    packed_word = fp_pack(sign_q, exp_field, mant_field);
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (enable) begin
          sign_d  = in_sign;
          mag_d   = in_mag;
          cnt_d   = '0;
          zero_d  = (data == '0);
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (!enable) begin
          // Initiator withdrew: abandon silently, result untouched.
          state_d = ST_IDLE;
        end else if (zero_q) begin
          result_d = 32'h0000_0000;
          done_d   = 1'b1;
          state_d  = ST_HOLD;
        end else if (!mag_q[WIDTH-1]) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = packed_word;
          done_d   = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      result_q <= 32'h0000_0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Bench for fixed_to_float_seq (WIDTH=22, FRAC_BITS=20).
// Expected results come from a real-valued model: the operand is turned into
// a real, encoded with $realtobits and re-biased to single precision. Latency
// is derived from the binary exponent of that real.
module tb_fixed_to_float_seq;

  localparam int W    = 22;
  localparam int FRAC = 20;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [W-1:0]  data;
  logic [31:0]   result;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'h0;
  logic        done_prev   = 1'b0;

  fixed_to_float_seq #(.WIDTH(W), .FRAC_BITS(FRAC)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .data   (data),
    .result (result),
    .done   (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_f(input logic [W-1:0] d);
    real r;
    logic [63:0] b;
    int e;
    r = $itor($signed(d)) / (2.0 ** FRAC);
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Edges from the accepting edge to done: the leading one of |d| sits at
  // bit position p = unbiased exponent + FRAC, and each missing bit above it
  // costs one edge, plus one edge to pack.
  function automatic int model_lat(input logic [W-1:0] d);
    real r;
    logic [63:0] b;
    int p;
    r = $itor($signed(d)) / (2.0 ** FRAC);
    if (r == 0.0) return 1;
    b = $realtobits(r);
    p = int'(b[62:52]) - 1023 + FRAC;
    return W - p;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: on every falling edge the result must either be the
  // next expected conversion (when done has just risen) or unchanged.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_result = 32'h0;
        done_prev   = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {31'b0, done}, 32'h0);
          end else begin
            last_result = exp_q.pop_front();
            check("result_model", result, last_result);
          end
        end else begin
          check("result_stable", result, last_result);
        end
        done_prev = done;
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left on a falling edge. Leaves enable low for exactly one
  // rising edge, so a call that follows immediately re-requests after the
  // minimum gap.
  task automatic run_conv(input logic [W-1:0] d, input int hold,
                          output logic [31:0] r, output int n);
    int lat;
    lat = model_lat(d);
    exp_q.push_back(model_f(d));
    data   = d;
    enable = 1'b1;
    @(posedge clk);               // accepting edge
    #1 data = W'($urandom);       // must be ignored from here on
    n = 0;
    while (!done && n < 64) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done) exp_q.delete();
    check("latency", 32'(n), 32'(lat));
    r = result;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("done_held", {31'b0, done}, 32'h1);
    enable = 1'b0;
    @(negedge clk);
    check("done_cleared", {31'b0, done}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W-1:0] d;
    logic [31:0]  res;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] r;
    int n;
    logic [W-1:0] d;

    vecs[0] = '{22'h100000, 32'h3F80_0000, 2};   // 1.0
    vecs[1] = '{22'h300000, 32'hBF80_0000, 2};   // -1.0
    vecs[2] = '{22'h080000, 32'h3F00_0000, 3};   // 0.5
    vecs[3] = '{22'h000001, 32'h3580_0000, 22};  // 2^-20, worst case
    vecs[4] = '{22'h200000, 32'hC000_0000, 1};   // -2.0, most negative
    vecs[5] = '{22'h000000, 32'h0000_0000, 1};   // zero
    vecs[6] = '{22'h1FFFFF, 32'h3FFF_FFF8, 2};   // largest positive
    vecs[7] = '{22'h3FFFFF, 32'hB580_0000, 22};  // -2^-20

    reset  = 1'b1;
    enable = 1'b0;
    data   = '0;
    repeat (2) @(negedge clk);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Pin the model itself to hand-computed values.
    foreach (vecs[i]) begin
      check("model_pin", model_f(vecs[i].d), vecs[i].res);
      check("model_lat_pin", 32'(model_lat(vecs[i].d)), 32'(vecs[i].lat));
    end

    // Directed conversions against literal expectations.
    foreach (vecs[i]) begin
      run_conv(vecs[i].d, 0, r, n);
      check("directed_result", r, vecs[i].res);
      check("directed_latency", 32'(n), 32'(vecs[i].lat));
    end

    // Handshake: enable held 3 cycles past done, then a one-edge gap.
    run_conv(22'h0C0000, 3, r, n);
    check("hold_result", r, 32'h3F40_0000);
    check("hold_result_after", result, 32'h3F40_0000);
    run_conv(22'h040000, 0, r, n);
    check("rerequest_result", r, 32'h3E80_0000);

    // Enable dropped mid-normalisation: done never rises, result kept.
    data   = 22'h000001;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("abort_done", {31'b0, done}, 32'h0);
    end
    check("abort_result", result, 32'h3E80_0000);

    // Reset mid-normalisation clears outputs immediately.
    data   = 22'h000002;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    enable   = 1'b0;
    #1;
    check("midreset_done", {31'b0, done}, 32'h0);
    check("midreset_result", result, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    run_conv(22'h080000, 0, r, n);
    check("post_reset_result", r, 32'h3F00_0000);

    // Random sweep with magnitudes spread over all leading-zero counts.
    for (int i = 0; i < 1500; i++) begin
      d = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 1) == 1) d = -d;
      run_conv(d, $urandom_range(0, 2), r, n);
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
